// File: rtl/multi_seed_trace_filter.sv
// Trace-packet filter: per-seed XNOR popcount matched against enableable ranges,
// combined across seeds into a keep/drop decision with saturating statistics.
module multi_seed_trace_filter #(
  parameter int unsigned DATA_WIDTH      = 1024,
  parameter int unsigned NUM_OF_SEEDS    = 4,
  parameter int unsigned RANGES_PER_SEED = 2,
  parameter int unsigned STAT_WIDTH      = 32,
  localparam int unsigned CW  = $clog2(DATA_WIDTH + 1),
  localparam int unsigned SAW = $clog2(NUM_OF_SEEDS),
  localparam int unsigned RAW = (RANGES_PER_SEED > 1) ? $clog2(RANGES_PER_SEED) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       seed_we,
  input  logic [SAW-1:0]             seed_waddr,
  input  logic [DATA_WIDTH-1:0]      seed_wdata,
  input  logic                       range_we,
  input  logic [SAW-1:0]             range_seed_addr,
  input  logic [RAW-1:0]             range_addr,
  input  logic [CW-1:0]              lower_bound_in,
  input  logic [CW-1:0]              upper_bound_in,
  input  logic                       range_enable_in,
  input  logic [NUM_OF_SEEDS-1:0]    seed_enable_mask,
  input  logic                       combine_mode,
  input  logic                       invert,
  input  logic                       stats_clear,
  output logic                       out_valid,
  output logic                       keep_pkt,
  output logic                       drop_pkt,
  output logic [NUM_OF_SEEDS-1:0]    match_vector,
  output logic [NUM_OF_SEEDS*CW-1:0] bit_counts,
  output logic [STAT_WIDTH-1:0]      kept_count,
  output logic [STAT_WIDTH-1:0]      dropped_count,
  output logic                       busy
);

  // Configuration
  logic [DATA_WIDTH-1:0]      seed_q     [NUM_OF_SEEDS];
  logic [CW-1:0]              lower_q    [NUM_OF_SEEDS][RANGES_PER_SEED];
  logic [CW-1:0]              upper_q    [NUM_OF_SEEDS][RANGES_PER_SEED];
  logic [RANGES_PER_SEED-1:0] range_en_q [NUM_OF_SEEDS];

  // Pipeline
  logic                       s1_valid_q, s1_en_q;
  logic [DATA_WIDTH-1:0]      s1_x_q     [NUM_OF_SEEDS];
  logic [DATA_WIDTH-1:0]      x_d        [NUM_OF_SEEDS];
  logic                       s2_valid_q, s2_en_q;
  logic [CW-1:0]              s2_cnt_q   [NUM_OF_SEEDS];
  logic [CW-1:0]              cnt_d      [NUM_OF_SEEDS];
  logic                       s3_valid_q, s3_keep_q;
  logic [NUM_OF_SEEDS-1:0]    s3_match_q;
  logic [NUM_OF_SEEDS*CW-1:0] s3_cnt_q;

  logic [NUM_OF_SEEDS-1:0]    seed_match;
  logic [NUM_OF_SEEDS*CW-1:0] cnt_flat;
  logic                       all_match, any_match, combined, keep_d;

  logic                       out_valid_q, keep_q;
  logic [NUM_OF_SEEDS-1:0]    match_vector_q;
  logic [NUM_OF_SEEDS*CW-1:0] bit_counts_q;
  logic [STAT_WIDTH-1:0]      kept_q, dropped_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_OF_SEEDS; s++) begin
        seed_q[s] <= '0;
        for (int r = 0; r < RANGES_PER_SEED; r++) begin
          lower_q[s][r]    <= '0;
          upper_q[s][r]    <= '1;
          range_en_q[s][r] <= (r == 0);
        end
      end
    end else begin
      if (seed_we) begin
        seed_q[seed_waddr] <= seed_wdata;
      end
      if (range_we) begin
        lower_q[range_seed_addr][range_addr]    <= lower_bound_in;
        upper_q[range_seed_addr][range_addr]    <= upper_bound_in;
        range_en_q[range_seed_addr][range_addr] <= range_enable_in;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_OF_SEEDS; s++) begin
      x_d[s]   = ~(data_in ^ seed_q[s]);
      cnt_d[s] = CW'($countones(s1_x_q[s]));
    end
  end

  // Range match and seed combine, evaluated on the S2 counts and captured into S3
  always_comb begin
    seed_match = '0;
    cnt_flat   = '0;
    for (int s = 0; s < NUM_OF_SEEDS; s++) begin
      cnt_flat[s*CW +: CW] = s2_cnt_q[s];
      for (int r = 0; r < RANGES_PER_SEED; r++) begin
        if (range_en_q[s][r] && (s2_cnt_q[s] >= lower_q[s][r]) &&
            (s2_cnt_q[s] <= upper_q[s][r])) begin
          seed_match[s] = 1'b1;
        end
      end
    end
    all_match = &(seed_match | ~seed_enable_mask);
    any_match = |(seed_match & seed_enable_mask);
    if (seed_enable_mask == '0) begin
      combined = 1'b1;
    end else begin
      combined = combine_mode ? any_match : all_match;
    end
    keep_d = s2_en_q & (combined ^ invert);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_en_q        <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_en_q        <= 1'b0;
      s3_valid_q     <= 1'b0;
      s3_keep_q      <= 1'b0;
      s3_match_q     <= '0;
      s3_cnt_q       <= '0;
      out_valid_q    <= 1'b0;
      keep_q         <= 1'b0;
      match_vector_q <= '0;
      bit_counts_q   <= '0;
      for (int s = 0; s < NUM_OF_SEEDS; s++) begin
        s1_x_q[s]   <= '0;
        s2_cnt_q[s] <= '0;
      end
    end else begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      s3_valid_q  <= s2_valid_q;
      out_valid_q <= s3_valid_q;
      if (in_valid) begin
        s1_en_q <= en;
        for (int s = 0; s < NUM_OF_SEEDS; s++) begin
          s1_x_q[s] <= x_d[s];
        end
      end
      if (s1_valid_q) begin
        s2_en_q <= s1_en_q;
        for (int s = 0; s < NUM_OF_SEEDS; s++) begin
          s2_cnt_q[s] <= cnt_d[s];
        end
      end
      if (s2_valid_q) begin
        s3_keep_q  <= keep_d;
        s3_match_q <= seed_match;
        s3_cnt_q   <= cnt_flat;
      end
      // Outputs hold their last decision between packets
      if (s3_valid_q) begin
        keep_q         <= s3_keep_q;
        match_vector_q <= s3_match_q;
        bit_counts_q   <= s3_cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kept_q    <= '0;
      dropped_q <= '0;
    end else if (stats_clear) begin
      kept_q    <= '0;
      dropped_q <= '0;
    end else if (out_valid_q) begin
      if (keep_q) begin
        if (kept_q != '1) kept_q <= kept_q + STAT_WIDTH'(1);
      end else begin
        if (dropped_q != '1) dropped_q <= dropped_q + STAT_WIDTH'(1);
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign keep_pkt      = keep_q;
  assign drop_pkt      = ~keep_q;
  assign match_vector  = match_vector_q;
  assign bit_counts    = bit_counts_q;
  assign kept_count    = kept_q;
  assign dropped_count = dropped_q;
  assign busy          = s1_valid_q | s2_valid_q | s3_valid_q;

endmodule

// File: tb/tb_multi_seed_trace_filter.sv
// Directed bench for multi_seed_trace_filter: table of packet vectors plus
// hand-written sequences for sweep, mid-flight reset and counter saturation.
module tb_multi_seed_trace_filter;

  localparam int unsigned DW = 16;
  localparam int unsigned NS = 2;
  localparam int unsigned NR = 2;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, in_valid;
  logic [DW-1:0] data_in;
  logic          seed_we;
  logic          seed_waddr;
  logic [DW-1:0] seed_wdata;
  logic          range_we;
  logic          range_seed_addr;
  logic          range_addr;
  logic [CW-1:0] lower_bound_in, upper_bound_in;
  logic          range_enable_in;
  logic [NS-1:0] seed_enable_mask;
  logic          combine_mode, invert, stats_clear;
  logic          out_valid, keep_pkt, drop_pkt;
  logic [NS-1:0] match_vector;
  logic [NS*CW-1:0] bit_counts;
  logic [SW-1:0] kept_count, dropped_count;
  logic          busy;

  multi_seed_trace_filter #(
    .DATA_WIDTH     (DW),
    .NUM_OF_SEEDS   (NS),
    .RANGES_PER_SEED(NR),
    .STAT_WIDTH     (SW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .in_valid        (in_valid),
    .data_in         (data_in),
    .seed_we         (seed_we),
    .seed_waddr      (seed_waddr),
    .seed_wdata      (seed_wdata),
    .range_we        (range_we),
    .range_seed_addr (range_seed_addr),
    .range_addr      (range_addr),
    .lower_bound_in  (lower_bound_in),
    .upper_bound_in  (upper_bound_in),
    .range_enable_in (range_enable_in),
    .seed_enable_mask(seed_enable_mask),
    .combine_mode    (combine_mode),
    .invert          (invert),
    .stats_clear     (stats_clear),
    .out_valid       (out_valid),
    .keep_pkt        (keep_pkt),
    .drop_pkt        (drop_pkt),
    .match_vector    (match_vector),
    .bit_counts      (bit_counts),
    .kept_count      (kept_count),
    .dropped_count   (dropped_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          en;
    logic [NS-1:0] mask;
    logic          mode;
    logic          inv;
    logic [NS-1:0] mv;
    logic [CW-1:0] c0;
    logic [CW-1:0] c1;
    logic          keep;
  } vec_t;

  vec_t vecs [13];
  int   n_err = 0;
  int   n_checks = 0;
  int   exp_kept = 0;
  int   exp_dropped = 0;
  int   mon_out = 0;
  int   mon_bad = 0;

  // Output monitor: counts decisions and any seed-0 match or keep
  always @(negedge clk) begin
    if (out_valid) begin
      mon_out <= mon_out + 1;
      if (match_vector[0] || keep_pkt) mon_bad <= mon_bad + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic write_seed(input logic idx, input logic [DW-1:0] val);
    seed_we = 1'b1; seed_waddr = idx; seed_wdata = val;
    tick();
    seed_we = 1'b0;
  endtask

  task automatic write_range(input logic s, input logic r, input logic [CW-1:0] lo,
                             input logic [CW-1:0] hi, input logic e);
    range_we = 1'b1; range_seed_addr = s; range_addr = r;
    lower_bound_in = lo; upper_bound_in = hi; range_enable_in = e;
    tick();
    range_we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    data_in = v.data; en = v.en; seed_enable_mask = v.mask;
    combine_mode = v.mode; invert = v.inv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, ".busy"}, busy, 1);
    tick();
    tick();
    check({tag, ".early_valid"}, out_valid, 0);
    tick();
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".keep"}, keep_pkt, v.keep);
    check({tag, ".drop"}, drop_pkt, !v.keep);
    check({tag, ".match_vector"}, match_vector, v.mv);
    check({tag, ".bit_counts"}, bit_counts, {v.c1, v.c0});
    if (v.keep) begin
      if (exp_kept < 15) exp_kept++;
    end else begin
      if (exp_dropped < 15) exp_dropped++;
    end
    tick();
    check({tag, ".single_pulse"}, out_valid, 0);
    check({tag, ".kept_count"}, kept_count, exp_kept);
    check({tag, ".dropped_count"}, dropped_count, exp_dropped);
  endtask

  initial begin
    int b_out, b_bad;
    //          data      en    mask   mode  inv   mv     c0     c1     keep
    vecs[0]  = '{16'h1234, 1'b1, 2'b00, 1'b0, 1'b0, 2'b11, 5'd11, 5'd11, 1'b1};
    vecs[1]  = '{16'h00FF, 1'b1, 2'b01, 1'b0, 1'b0, 2'b11, 5'd8,  5'd8,  1'b1};
    vecs[2]  = '{16'hFFFF, 1'b1, 2'b01, 1'b0, 1'b0, 2'b10, 5'd0,  5'd0,  1'b0};
    vecs[3]  = '{16'h00FF, 1'b1, 2'b11, 1'b0, 1'b0, 2'b01, 5'd8,  5'd8,  1'b0};
    vecs[4]  = '{16'h00FF, 1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 5'd8,  5'd8,  1'b1};
    vecs[5]  = '{16'h00FF, 1'b1, 2'b11, 1'b1, 1'b0, 2'b11, 5'd8,  5'd8,  1'b1};
    vecs[6]  = '{16'h00FF, 1'b1, 2'b11, 1'b1, 1'b1, 2'b11, 5'd8,  5'd8,  1'b0};
    vecs[7]  = '{16'hFFFF, 1'b1, 2'b11, 1'b0, 1'b0, 2'b10, 5'd0,  5'd16, 1'b0};
    vecs[8]  = '{16'hFFFF, 1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 5'd0,  5'd16, 1'b1};
    vecs[9]  = '{16'h00FF, 1'b0, 2'b11, 1'b1, 1'b0, 2'b11, 5'd8,  5'd8,  1'b0};
    vecs[10] = '{16'hFFFF, 1'b1, 2'b00, 1'b0, 1'b0, 2'b10, 5'd0,  5'd16, 1'b1};
    vecs[11] = '{16'hFFFF, 1'b1, 2'b00, 1'b1, 1'b1, 2'b10, 5'd0,  5'd16, 1'b0};
    vecs[12] = '{16'hFFFF, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 5'd0,  5'd16, 1'b1};

    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; data_in = '0;
    seed_we = 1'b0; seed_waddr = 1'b0; seed_wdata = '0;
    range_we = 1'b0; range_seed_addr = 1'b0; range_addr = 1'b0;
    lower_bound_in = '0; upper_bound_in = '0; range_enable_in = 1'b0;
    seed_enable_mask = '0; combine_mode = 1'b0; invert = 1'b0; stats_clear = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("reset.out_valid", out_valid, 0);
    check("reset.keep", keep_pkt, 0);
    check("reset.drop", drop_pkt, 1);
    check("reset.match_vector", match_vector, 0);
    check("reset.bit_counts", bit_counts, 0);
    check("reset.kept", kept_count, 0);
    check("reset.dropped", dropped_count, 0);
    check("reset.busy", busy, 0);

    for (int i = 0; i < 13; i++) begin
      if (i == 1) begin
        write_seed(1'b0, 16'h0000);
        write_range(1'b0, 1'b0, 5'd6, 5'd9, 1'b1);
      end
      if (i == 3) begin
        write_seed(1'b1, 16'hFFFF);
        write_range(1'b1, 1'b0, 5'd12, 5'd16, 1'b1);
      end
      if (i == 5) write_range(1'b1, 1'b1, 5'd8, 5'd8, 1'b1);
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Inverted bounds on seed 0's only enabled range: full back-to-back sweep
    write_range(1'b0, 1'b0, 5'd10, 5'd5, 1'b1);
    en = 1'b1; seed_enable_mask = 2'b01; combine_mode = 1'b0; invert = 1'b0;
    b_out = mon_out; b_bad = mon_bad;
    for (int i = 0; i < 65536; i++) begin
      in_valid = 1'b1; data_in = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    check("sweep.outputs", mon_out - b_out, 65536);
    check("sweep.never_match", mon_bad - b_bad, 0);
    check("sweep.busy_idle", busy, 0);

    // Reset after the second of five back-to-back packets
    b_out = mon_out;
    en = 1'b1; seed_enable_mask = 2'b00;
    in_valid = 1'b1; data_in = 16'h0001; tick();
    data_in = 16'h0002; tick();
    rst_n = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      data_in = 16'(i); tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (6) tick();
    check("midreset.no_out_valid", mon_out - b_out, 0);
    check("midreset.kept", kept_count, 0);
    check("midreset.dropped", dropped_count, 0);
    check("midreset.busy", busy, 0);
    check("midreset.drop", drop_pkt, 1);
    exp_kept = 0; exp_dropped = 0;
    run_vec(vecs[0], "postreset_cfg");

    // Saturation of dropped_count and clear-over-increment priority
    stats_clear = 1'b1; tick(); stats_clear = 1'b0;
    check("clear.kept", kept_count, 0);
    en = 1'b0; in_valid = 1'b1;
    repeat (14) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("sat.dropped14", dropped_count, 14);
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("sat.dropped15", dropped_count, 15);
    check("sat.kept", kept_count, 0);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (3) tick();
    check("clearpri.out_valid", out_valid, 1);
    stats_clear = 1'b1; tick(); stats_clear = 1'b0;
    check("clearpri.dropped", dropped_count, 0);
    check("clearpri.kept", kept_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
